// File: rtl/rr_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mem_controller_pkg
// Description : Shared channel state encoding and width helper for the
//               round-robin memory controller and its client benches.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mem_controller_pkg;

  // Per-channel transaction state
  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_READ_WAITING   = 3'd1,
    ST_WRITE_WAITING  = 3'd2,
    ST_READ_RELAYING  = 3'd3,
    ST_WRITE_RELAYING = 3'd4
  } ch_state_e;

  // $clog2 clamped to at least one bit so degenerate sizes still get a vector
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Picks the first asserted
//               request at or after the pointer, wrapping around; one-hot out.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import rr_mem_controller_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requests in pointer order and grant the first one found
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : rr_mem_controller
// Description : Shares NUM_CHANNELS memory channels among NUM_CONSUMERS
//               fetchers/LSUs with round-robin arbitration, optional
//               read-only mode and optional memory response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mem_controller
  import rr_mem_controller_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  // Consumer side
  input  logic [NUM_CONSUMERS-1:0]                 c_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  c_read_address,
  output logic [NUM_CONSUMERS-1:0]                 c_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  c_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 c_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  c_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  c_write_data,
  output logic [NUM_CONSUMERS-1:0]                 c_write_ready,
  output logic [NUM_CONSUMERS-1:0]                 c_error,
  // Memory side
  output logic [NUM_CHANNELS-1:0]                  m_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   m_read_address,
  input  logic [NUM_CHANNELS-1:0]                  m_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   m_read_data,
  output logic [NUM_CHANNELS-1:0]                  m_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   m_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   m_write_data,
  input  logic [NUM_CHANNELS-1:0]                  m_write_ready
);

  localparam int CW = clog2_min1(NUM_CONSUMERS);
  localparam int TW = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  // Channel state
  ch_state_e                           state_q [NUM_CHANNELS];
  ch_state_e                           state_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][CW-1:0]     cons_q, cons_d;
  logic [NUM_CHANNELS-1:0][TW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]                       ptr_q, ptr_d;

  // Registered outputs
  logic [NUM_CHANNELS-1:0]                 m_read_valid_q, m_read_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_read_address_q, m_read_address_d;
  logic [NUM_CHANNELS-1:0]                 m_write_valid_q, m_write_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_write_address_q, m_write_address_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_write_data_q, m_write_data_d;
  logic [NUM_CONSUMERS-1:0]                c_read_ready_q, c_read_ready_d;
  logic [NUM_CONSUMERS-1:0]                c_write_ready_q, c_write_ready_d;
  logic [NUM_CONSUMERS-1:0]                c_error_q, c_error_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_read_data_q, c_read_data_d;

  // Arbitration
  logic [NUM_CONSUMERS-1:0]                   w_owned;
  logic [NUM_CONSUMERS-1:0]                   w_eligible;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] w_grant;
  logic [CW-1:0]                              gnt_idx;
  logic [CW-1:0]                              own_idx;

  assign m_read_valid    = m_read_valid_q;
  assign m_read_address  = m_read_address_q;
  assign m_write_valid   = m_write_valid_q;
  assign m_write_address = m_write_address_q;
  assign m_write_data    = m_write_data_q;
  assign c_read_ready    = c_read_ready_q;
  assign c_write_ready   = c_write_ready_q;
  assign c_error         = c_error_q;
  assign c_read_data     = c_read_data_q;

  // A consumer is owned while any non-idle channel is serving it
  always_comb begin
    w_owned = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (state_q[k] != ST_IDLE) w_owned[cons_q[k]] = 1'b1;
    end
  end

  assign w_eligible = (c_read_valid | c_write_valid) & ~w_owned;

  // Arbiter chain: each channel sees the requests left over by lower channels
  generate
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
      logic [NUM_CONSUMERS-1:0] w_mask;
      logic [NUM_CONSUMERS-1:0] w_req;
      logic [NUM_CONSUMERS-1:0] w_gnt;
      if (k == 0) begin : g_head
        assign w_mask = w_eligible;
      end else begin : g_tail
        assign w_mask = g_chan[k-1].w_mask & ~g_chan[k-1].w_gnt;
      end
      assign w_req = w_mask & {NUM_CONSUMERS{state_q[k] == ST_IDLE}};
      rr_arbiter #(
        .N  (NUM_CONSUMERS),
        .PW (CW)
      ) u_arb (
        .req_i   (w_req),
        .ptr_i   (ptr_q),
        .grant_o (w_gnt)
      );
      assign w_grant[k] = w_gnt;
    end
  endgenerate

  // Next-state and output logic for every channel
  always_comb begin
    state_d           = state_q;
    cons_d            = cons_q;
    cnt_d             = cnt_q;
    ptr_d             = ptr_q;
    m_read_valid_d    = m_read_valid_q;
    m_read_address_d  = m_read_address_q;
    m_write_valid_d   = m_write_valid_q;
    m_write_address_d = m_write_address_q;
    m_write_data_d    = m_write_data_q;
    c_read_ready_d    = c_read_ready_q;
    c_write_ready_d   = c_write_ready_q;
    c_error_d         = c_error_q;
    c_read_data_d     = c_read_data_q;
    gnt_idx           = '0;
    own_idx           = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      own_idx = cons_q[k];
      gnt_idx = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (w_grant[k][i]) gnt_idx = CW'(i);
      end
      case (state_q[k])
        ST_IDLE: begin
          if (|w_grant[k]) begin
            cons_d[k] = gnt_idx;
            cnt_d[k]  = '0;
            // Later channels overwrite this, leaving the pointer past the last grant
            ptr_d = (gnt_idx == CW'(NUM_CONSUMERS - 1)) ? '0 : gnt_idx + CW'(1);
            if (c_read_valid[gnt_idx]) begin
              state_d[k]          = ST_READ_WAITING;
              m_read_valid_d[k]   = 1'b1;
              m_read_address_d[k] = c_read_address[gnt_idx];
            end else begin
              state_d[k] = ST_WRITE_WAITING;
              if (WRITE_ENABLE != 0) begin
                m_write_valid_d[k]   = 1'b1;
                m_write_address_d[k] = c_write_address[gnt_idx];
                m_write_data_d[k]    = c_write_data[gnt_idx];
              end
            end
          end
        end
        ST_READ_WAITING: begin
          if (m_read_ready[k]) begin
            m_read_valid_d[k]       = 1'b0;
            c_read_ready_d[own_idx] = 1'b1;
            c_error_d[own_idx]      = 1'b0;
            c_read_data_d[own_idx]  = m_read_data[k];
            state_d[k]              = ST_READ_RELAYING;
          end else if (TIMEOUT_CYCLES > 0) begin
            if (cnt_q[k] == TO_LAST) begin
              m_read_valid_d[k]       = 1'b0;
              c_read_ready_d[own_idx] = 1'b1;
              c_error_d[own_idx]      = 1'b1;
              c_read_data_d[own_idx]  = '0;
              state_d[k]              = ST_READ_RELAYING;
            end else begin
              cnt_d[k] = cnt_q[k] + TW'(1);
            end
          end
        end
        ST_WRITE_WAITING: begin
          if (WRITE_ENABLE == 0) begin
            // Read-only memory: reject the write without touching the bus
            c_write_ready_d[own_idx] = 1'b1;
            c_error_d[own_idx]       = 1'b1;
            state_d[k]               = ST_WRITE_RELAYING;
          end else if (m_write_ready[k]) begin
            m_write_valid_d[k]       = 1'b0;
            c_write_ready_d[own_idx] = 1'b1;
            c_error_d[own_idx]       = 1'b0;
            state_d[k]               = ST_WRITE_RELAYING;
          end else if (TIMEOUT_CYCLES > 0) begin
            if (cnt_q[k] == TO_LAST) begin
              m_write_valid_d[k]       = 1'b0;
              c_write_ready_d[own_idx] = 1'b1;
              c_error_d[own_idx]       = 1'b1;
              state_d[k]               = ST_WRITE_RELAYING;
            end else begin
              cnt_d[k] = cnt_q[k] + TW'(1);
            end
          end
        end
        ST_READ_RELAYING: begin
          if (!c_read_valid[own_idx]) begin
            c_read_ready_d[own_idx] = 1'b0;
            c_error_d[own_idx]      = 1'b0;
            state_d[k]              = ST_IDLE;
          end
        end
        ST_WRITE_RELAYING: begin
          if (!c_write_valid[own_idx]) begin
            c_write_ready_d[own_idx] = 1'b0;
            c_error_d[own_idx]       = 1'b0;
            state_d[k]               = ST_IDLE;
          end
        end
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) state_q[k] <= ST_IDLE;
      cons_q            <= '0;
      cnt_q             <= '0;
      ptr_q             <= '0;
      m_read_valid_q    <= '0;
      m_read_address_q  <= '0;
      m_write_valid_q   <= '0;
      m_write_address_q <= '0;
      m_write_data_q    <= '0;
      c_read_ready_q    <= '0;
      c_write_ready_q   <= '0;
      c_error_q         <= '0;
      c_read_data_q     <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) state_q[k] <= state_d[k];
      cons_q            <= cons_d;
      cnt_q             <= cnt_d;
      ptr_q             <= ptr_d;
      m_read_valid_q    <= m_read_valid_d;
      m_read_address_q  <= m_read_address_d;
      m_write_valid_q   <= m_write_valid_d;
      m_write_address_q <= m_write_address_d;
      m_write_data_q    <= m_write_data_d;
      c_read_ready_q    <= c_read_ready_d;
      c_write_ready_q   <= c_write_ready_d;
      c_error_q         <= c_error_d;
      c_read_data_q     <= c_read_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mem_controller
// Description : Directed self-checking bench. dut_a uses the default
//               configuration; dut_b is a single-channel, read-only block with
//               a 5-cycle memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mem_controller;

  logic clk;
  logic reset;

  // dut_a signals (4 consumers, 2 channels)
  logic [3:0]       c_read_valid_a, c_read_ready_a, c_write_valid_a, c_write_ready_a, c_error_a;
  logic [3:0][7:0]  c_read_address_a, c_write_address_a;
  logic [3:0][15:0] c_read_data_a, c_write_data_a;
  logic [1:0]       m_read_valid_a, m_read_ready_a, m_write_valid_a, m_write_ready_a;
  logic [1:0][7:0]  m_read_address_a, m_write_address_a;
  logic [1:0][15:0] m_read_data_a, m_write_data_a;

  // dut_b signals (4 consumers, 1 channel)
  logic [3:0]       c_read_valid_b, c_read_ready_b, c_write_valid_b, c_write_ready_b, c_error_b;
  logic [3:0][7:0]  c_read_address_b, c_write_address_b;
  logic [3:0][15:0] c_read_data_b, c_write_data_b;
  logic [0:0]       m_read_valid_b, m_read_ready_b, m_write_valid_b, m_write_ready_b;
  logic [0:0][7:0]  m_read_address_b, m_write_address_b;
  logic [0:0][15:0] m_read_data_b, m_write_data_b;

  int n_checks = 0;
  int n_errors = 0;

  rr_mem_controller dut_a (
    .clk (clk), .reset (reset),
    .c_read_valid (c_read_valid_a), .c_read_address (c_read_address_a),
    .c_read_ready (c_read_ready_a), .c_read_data (c_read_data_a),
    .c_write_valid (c_write_valid_a), .c_write_address (c_write_address_a),
    .c_write_data (c_write_data_a), .c_write_ready (c_write_ready_a), .c_error (c_error_a),
    .m_read_valid (m_read_valid_a), .m_read_address (m_read_address_a),
    .m_read_ready (m_read_ready_a), .m_read_data (m_read_data_a),
    .m_write_valid (m_write_valid_a), .m_write_address (m_write_address_a),
    .m_write_data (m_write_data_a), .m_write_ready (m_write_ready_a)
  );

  rr_mem_controller #(
    .NUM_CHANNELS (1), .WRITE_ENABLE (0), .TIMEOUT_CYCLES (5)
  ) dut_b (
    .clk (clk), .reset (reset),
    .c_read_valid (c_read_valid_b), .c_read_address (c_read_address_b),
    .c_read_ready (c_read_ready_b), .c_read_data (c_read_data_b),
    .c_write_valid (c_write_valid_b), .c_write_address (c_write_address_b),
    .c_write_data (c_write_data_b), .c_write_ready (c_write_ready_b), .c_error (c_error_b),
    .m_read_valid (m_read_valid_b), .m_read_address (m_read_address_b),
    .m_read_ready (m_read_ready_b), .m_read_data (m_read_data_b),
    .m_write_valid (m_write_valid_b), .m_write_address (m_write_address_b),
    .m_write_data (m_write_data_b), .m_write_ready (m_write_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_c;
    reset = 1'b1;
    c_read_valid_a = '0; c_read_address_a = '0; c_write_valid_a = '0;
    c_write_address_a = '0; c_write_data_a = '0;
    m_read_ready_a = '0; m_read_data_a = '0; m_write_ready_a = '0;
    c_read_valid_b = '0; c_read_address_b = '0; c_write_valid_b = '0;
    c_write_address_b = '0; c_write_data_b = '0;
    m_read_ready_b = '0; m_read_data_b = '0; m_write_ready_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_read_valid", 32'(m_read_valid_a), 32'h0);
    check_eq("rst_c_read_ready", 32'(c_read_ready_a), 32'h0);
    check_eq("rst_c_error", 32'(c_error_a), 32'h0);
    check_eq("rst_m_write_valid_b", 32'(m_write_valid_b), 32'h0);
    reset = 1'b0;

    // Four simultaneous reads on two channels
    c_read_valid_a = 4'b1111;
    for (int i = 0; i < 4; i++) c_read_address_a[i] = 8'(8'h40 + i);
    tick();
    check_eq("rd4_m_valid", 32'(m_read_valid_a), 32'h3);
    check_eq("rd4_ch0_addr", 32'(m_read_address_a[0]), 32'h40);
    check_eq("rd4_ch1_addr", 32'(m_read_address_a[1]), 32'h41);
    tick();
    m_read_ready_a = 2'b11; m_read_data_a[0] = 16'h1111; m_read_data_a[1] = 16'h2222;
    tick();
    check_eq("rd4_c_ready_01", 32'(c_read_ready_a), 32'h3);
    check_eq("rd4_c0_data", 32'(c_read_data_a[0]), 32'h1111);
    check_eq("rd4_c1_data", 32'(c_read_data_a[1]), 32'h2222);
    check_eq("rd4_m_valid_drop", 32'(m_read_valid_a), 32'h0);
    m_read_ready_a = 2'b00; c_read_valid_a = 4'b1100;
    tick();
    check_eq("rd4_release", 32'(c_read_ready_a), 32'h0);
    tick();
    check_eq("rd4_ch0_addr2", 32'(m_read_address_a[0]), 32'h42);
    check_eq("rd4_ch1_addr2", 32'(m_read_address_a[1]), 32'h43);
    check_eq("rd4_m_valid2", 32'(m_read_valid_a), 32'h3);
    m_read_ready_a = 2'b11; m_read_data_a[0] = 16'h3333; m_read_data_a[1] = 16'h4444;
    tick();
    check_eq("rd4_c_ready_23", 32'(c_read_ready_a), 32'hC);
    check_eq("rd4_c2_data", 32'(c_read_data_a[2]), 32'h3333);
    check_eq("rd4_c3_data", 32'(c_read_data_a[3]), 32'h4444);
    check_eq("rd4_c0_data_hold", 32'(c_read_data_a[0]), 32'h1111);
    m_read_ready_a = 2'b00; c_read_valid_a = 4'b0000;
    tick();
    check_eq("rd4_release2", 32'(c_read_ready_a), 32'h0);

    // Write from c0 plus read from c3; pointer is back at 0 so ch0 takes c0
    c_write_valid_a[0] = 1'b1; c_write_address_a[0] = 8'h10; c_write_data_a[0] = 16'hBEEF;
    c_read_valid_a[3] = 1'b1;  c_read_address_a[3] = 8'h33;
    tick();
    check_eq("wr_m_write_valid", 32'(m_write_valid_a), 32'h1);
    check_eq("wr_m_write_addr", 32'(m_write_address_a[0]), 32'h10);
    check_eq("wr_m_write_data", 32'(m_write_data_a[0]), 32'hBEEF);
    check_eq("wr_m_read_valid", 32'(m_read_valid_a), 32'h2);
    check_eq("wr_m_read_addr", 32'(m_read_address_a[1]), 32'h33);
    m_write_ready_a = 2'b01; m_read_ready_a = 2'b10; m_read_data_a[1] = 16'h5555;
    tick();
    check_eq("wr_c_write_ready", 32'(c_write_ready_a), 32'h1);
    check_eq("wr_c_error", 32'(c_error_a), 32'h0);
    check_eq("wr_c_read_ready", 32'(c_read_ready_a), 32'h8);
    check_eq("wr_c3_data", 32'(c_read_data_a[3]), 32'h5555);
    check_eq("wr_m_write_valid_drop", 32'(m_write_valid_a), 32'h0);
    m_write_ready_a = 2'b00; m_read_ready_a = 2'b00;
    c_write_valid_a = 4'b0000; c_read_valid_a = 4'b0000;
    tick();
    check_eq("wr_release", 32'(c_write_ready_a), 32'h0);

    // Read and write together from c2: read wins
    c_read_valid_a[2] = 1'b1;  c_read_address_a[2] = 8'h22;
    c_write_valid_a[2] = 1'b1; c_write_address_a[2] = 8'h77;
    tick();
    check_eq("rw_m_read_valid", 32'(m_read_valid_a), 32'h1);
    check_eq("rw_m_read_addr", 32'(m_read_address_a[0]), 32'h22);
    check_eq("rw_m_write_valid", 32'(m_write_valid_a), 32'h0);
    m_read_ready_a = 2'b01; m_read_data_a[0] = 16'h6666;
    tick();
    check_eq("rw_c_read_ready", 32'(c_read_ready_a), 32'h4);
    check_eq("rw_c_write_ready", 32'(c_write_ready_a), 32'h0);
    m_read_ready_a = 2'b00; c_read_valid_a = 4'b0000; c_write_valid_a = 4'b0000;
    tick();

    // Asynchronous reset while a read is waiting on memory
    c_read_valid_a[1] = 1'b1; c_read_address_a[1] = 8'h51;
    tick();
    check_eq("ar_pre_m_valid", 32'(m_read_valid_a), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_m_valid", 32'(m_read_valid_a), 32'h0);
    check_eq("ar_m_addr", 32'(m_read_address_a[0]), 32'h0);
    check_eq("ar_c3_data", 32'(c_read_data_a[3]), 32'h0);
    check_eq("ar_c0_data", 32'(c_read_data_a[0]), 32'h0);
    reset = 1'b0;
    tick();
    check_eq("ar_regrant_valid", 32'(m_read_valid_a), 32'h1);
    check_eq("ar_regrant_addr", 32'(m_read_address_a[0]), 32'h51);
    m_read_ready_a = 2'b01; m_read_data_a[0] = 16'h7777;
    tick();
    check_eq("ar_c_read_ready", 32'(c_read_ready_a), 32'h2);
    check_eq("ar_c1_data", 32'(c_read_data_a[1]), 32'h7777);
    m_read_ready_a = 2'b00; c_read_valid_a = 4'b0000;
    tick();

    // dut_b: c1 and c2 keep requesting on a single channel; grants alternate
    m_read_ready_b = 1'b1;
    c_read_address_b[1] = 8'h01; c_read_address_b[2] = 8'h02;
    c_read_valid_b = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0) ? 1 : 2;
      m_read_data_b[0] = 16'(16'h0100 + i);
      tick();
      check_eq($sformatf("alt%0d_m_valid", i), 32'(m_read_valid_b), 32'h1);
      check_eq($sformatf("alt%0d_grant", i), 32'(m_read_address_b[0]), 32'(exp_c));
      tick();
      check_eq($sformatf("alt%0d_c_ready", i), 32'(c_read_ready_b), 32'(1) << exp_c);
      check_eq($sformatf("alt%0d_c_data", i), 32'(c_read_data_b[exp_c]), 32'(32'h100 + i));
      c_read_valid_b[exp_c] = 1'b0;
      tick();
      check_eq($sformatf("alt%0d_release", i), 32'(c_read_ready_b), 32'h0);
      c_read_valid_b[exp_c] = 1'b1;
    end
    c_read_valid_b = 4'b0000; m_read_ready_b = 1'b0;
    tick();

    // dut_b: memory never answers, timeout after 5 waiting cycles
    c_read_valid_b[1] = 1'b1; c_read_address_b[1] = 8'h0A;
    tick();
    check_eq("to_m_valid", 32'(m_read_valid_b), 32'h1);
    repeat (4) tick();
    check_eq("to_not_yet", 32'(c_read_ready_b), 32'h0);
    check_eq("to_m_valid_held", 32'(m_read_valid_b), 32'h1);
    tick();
    check_eq("to_c_ready", 32'(c_read_ready_b), 32'h2);
    check_eq("to_c_error", 32'(c_error_b), 32'h2);
    check_eq("to_c_data_zero", 32'(c_read_data_b[1]), 32'h0);
    check_eq("to_m_valid_drop", 32'(m_read_valid_b), 32'h0);
    c_read_valid_b[1] = 1'b0;
    tick();
    check_eq("to_release_ready", 32'(c_read_ready_b), 32'h0);
    check_eq("to_release_error", 32'(c_error_b), 32'h0);

    // dut_b: read-only block rejects a write from c3
    c_write_valid_b[3] = 1'b1; c_write_address_b[3] = 8'h20; c_write_data_b[3] = 16'h1234;
    tick();
    check_eq("ro_m_write_valid1", 32'(m_write_valid_b), 32'h0);
    check_eq("ro_c_write_ready1", 32'(c_write_ready_b), 32'h0);
    tick();
    check_eq("ro_c_write_ready", 32'(c_write_ready_b), 32'h8);
    check_eq("ro_c_error", 32'(c_error_b), 32'h8);
    check_eq("ro_m_write_valid2", 32'(m_write_valid_b), 32'h0);
    check_eq("ro_m_write_addr", 32'(m_write_address_b[0]), 32'h0);
    check_eq("ro_m_write_data", 32'(m_write_data_b[0]), 32'h0);
    c_write_valid_b[3] = 1'b0;
    tick();
    check_eq("ro_release_ready", 32'(c_write_ready_b), 32'h0);
    check_eq("ro_release_error", 32'(c_error_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
